data_destuffer: RTL and testbench
=================================

DATA_DESTUFFER -- requirements
Module: data_destuffer

Interface
REQ-001 Parameter MPT_W, default 8, width of the slot-count and data-count frame fields.
REQ-002 Parameter DATA_W, default 8, payload word width.
REQ-003 Ports: clk  input  1  single clock; all logic on rising edge.
REQ-004 Ports: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Ports: pm  input  MPT_W  slots per frame; sampled on the sof cycle only.
REQ-006 Ports: cm  input  MPT_W  data slots per frame; sampled on the sof cycle only.
REQ-007 Ports: sof  input  1  frame-start pulse; this cycle carries no slot.
REQ-008 Ports: valid_in  input  1  slot present this cycle.
REQ-009 Ports: ds_in  input  1  slot marker: 1 = data, 0 = stuff.
REQ-010 Ports: data_in  input  DATA_W  slot payload.
REQ-011 Ports: data_out  output  DATA_W  extracted data word.
REQ-012 Ports: data_valid  output  1  data_out holds a data word.
REQ-013 Ports: eof_out  output  1  pulse with the response to the frame's last slot.
REQ-014 Ports: frame_ok  output  1  pulse with eof_out; 1 if the frame had no pattern error and data count == cm.
REQ-015 Ports: err_pattern  output  1  pulse: ds_in disagreed with the expected marker for this slot.
REQ-016 Ports: err_sof  output  1  pulse: sof arrived while a frame was still open.
REQ-017 Ports: err_cfg  output  1  pulse: pm == 0 or cm > pm was sampled on sof.

Function
REQ-018 Expected marker for slot k (1..pm) SHALL be floor(k*cm/pm) - floor((k-1)*cm/pm).
REQ-019 Implementation SHALL use an accumulator starting at 0 per frame: acc += cm; if acc >= pm then expected = 1 and acc -= pm; accumulator width MPT_W+1, no divider.
REQ-020 FSM states SHALL be IDLE and RUN.
REQ-021 IDLE: on sof with valid config, latch pm/cm, clear slot counter, data counter, accumulator and error flag, go to RUN; on invalid config, pulse err_cfg and stay in IDLE.
REQ-022 IDLE: valid_in without a prior sof SHALL be ignored, with no output.
REQ-023 RUN: each valid_in cycle consumes one slot; cycles with valid_in = 0 SHALL leave all state unchanged.
REQ-024 Every output SHALL be registered with a latency of exactly 1 cycle from the slot cycle.
REQ-025 A slot with ds_in = 1 SHALL produce data_valid = 1 and data_out = data_in; a stuff slot SHALL produce data_valid = 0.
REQ-026 Forwarding SHALL follow ds_in even when ds_in is wrong; a mismatch additionally pulses err_pattern and sets the frame error flag.
REQ-027 On slot pm: pulse eof_out and frame_ok (when its condition holds), then return to IDLE.
REQ-028 sof in RUN: pulse err_sof, abandon the frame with no eof_out, then handle the sof as in REQ-021 in the same cycle.
REQ-029 sof and valid_in in the same cycle: the sof takes priority and the slot is not consumed.
REQ-030 cm == 0 SHALL expect all stuff; cm == pm SHALL expect all data.
REQ-031 Counters SHALL be MPT_W bits wide and SHALL never wrap within a legal frame.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, all counters and the accumulator to 0, and all outputs to 0 (data_out 0).
REQ-033 Reset mid-frame SHALL discard the frame; after release, the block SHALL wait for a new sof.

Structure
REQ-034 Package destuff_pkg SHALL hold the state enum (IDLE, RUN) and the default MPT_W/DATA_W constants.
REQ-035 Sub-module ds_pattern_gen SHALL hold the accumulator and produce the expected marker; its ports are clk, rst_n, load (sof), step (valid slot), pm, cm and exp_ds.

Verification
REQ-036 pm=4, cm=2, ds 0,1,0,1, data A0..A3 -> data_valid for A1 and A3 only, eof_out and frame_ok on the 4th response.
REQ-037 pm=5, cm=3, ds 0,1,0,1,1 with valid_in gaps between slots -> data 1,3,4 forwarded, frame_ok = 1; the same frame with ds 1,1,0,1,0 -> err_pattern on slots 1 and 5, frame_ok = 0.
REQ-038 pm=3, cm=3 and pm=3, cm=0 -> all slots forwarded / none forwarded respectively, frame_ok = 1 in both cases.
REQ-039 pm=6, cm=2 with sof after slot 3 -> err_sof, no eof_out, new frame starts cleanly; pm=0 or cm=7, pm=4 -> err_cfg, state stays IDLE.
REQ-040 rst_n low after slot 2 of a pm=4 frame -> outputs 0 at once; the next slots are ignored until a new sof.

Source files
------------

// File: rtl/destuff_pkg.sv
// Shared types and defaults for the frame destuffer.
// Holds the FSM encoding and default field widths.
package destuff_pkg;

  localparam int MPT_W_DEF  = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ds_pattern_gen.sv
// Expected data/stuff marker generator.
// Bresenham-style accumulator spreads cm data slots over pm.
module ds_pattern_gen #(
  parameter int MPT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [MPT_W-1:0] pm,
  input  logic [MPT_W-1:0] cm,
  output logic             exp_ds
);

  localparam int AW = MPT_W + 1;

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;

  // acc < pm and cm <= pm, so sum never exceeds 2*pm-1
  assign sum    = acc + AW'(cm);
  assign exp_ds = (sum >= AW'(pm));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= '0;
    end else if (step) begin
      acc <= exp_ds ? (sum - AW'(pm)) : sum;
    end
  end

endmodule

// File: rtl/data_destuffer.sv
// Extracts data words from a framed slot stream.
// Checks each slot marker against the expected pm/cm pattern.
module data_destuffer
  import destuff_pkg::*;
#(
  parameter int MPT_W  = MPT_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MPT_W-1:0]  pm,
  input  logic [MPT_W-1:0]  cm,
  input  logic              sof,
  input  logic              valid_in,
  input  logic              ds_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              eof_out,
  output logic              frame_ok,
  output logic              err_pattern,
  output logic              err_sof,
  output logic              err_cfg
);

  localparam int AW = MPT_W + 1;

  state_t           state_q;
  state_t           state_d;
  logic [MPT_W-1:0] pm_q;
  logic [MPT_W-1:0] cm_q;
  logic [MPT_W-1:0] slot_cnt;
  logic [MPT_W-1:0] data_cnt;
  logic             err_flag;
  logic             exp_ds;
  logic             cfg_ok;
  logic             slot;
  logic             last;
  logic             mis;
  logic             cnt_ok;

  logic [DATA_W-1:0] dout_d;
  logic              dv_d;
  logic              eof_d;
  logic              ok_d;
  logic              ep_d;
  logic              es_d;
  logic              ec_d;

  assign cfg_ok = (pm != '0) && (cm <= pm);
  assign slot   = (state_q == RUN) && valid_in && !sof;
  assign last   = (slot_cnt == (pm_q - MPT_W'(1)));
  assign mis    = (ds_in != exp_ds);
  assign cnt_ok = ((AW'(data_cnt) + AW'(ds_in)) == AW'(cm_q));

  ds_pattern_gen #(
    .MPT_W (MPT_W)
  ) u_pat (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (sof & cfg_ok),
    .step   (slot),
    .pm     (pm_q),
    .cm     (cm_q),
    .exp_ds (exp_ds)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // sof wins over any slot on the same cycle, in either state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (sof && cfg_ok) state_d = RUN;
      end
      RUN: begin
        if (sof)               state_d = cfg_ok ? RUN : IDLE;
        else if (slot && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dv_d   = slot && ds_in;
    dout_d = dv_d ? data_in : data_out;
    eof_d  = slot && last;
    ok_d   = eof_d && !err_flag && !mis && cnt_ok;
    ep_d   = slot && mis;
    es_d   = sof && (state_q == RUN);
    ec_d   = sof && !cfg_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q     <= '0;
      cm_q     <= '0;
      slot_cnt <= '0;
      data_cnt <= '0;
      err_flag <= 1'b0;
    end else if (sof) begin
      if (cfg_ok) begin
        pm_q     <= pm;
        cm_q     <= cm;
        slot_cnt <= '0;
        data_cnt <= '0;
        err_flag <= 1'b0;
      end
    end else if (slot) begin
      slot_cnt <= slot_cnt + MPT_W'(1);
      data_cnt <= data_cnt + MPT_W'(ds_in);
      if (mis) err_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      eof_out     <= 1'b0;
      frame_ok    <= 1'b0;
      err_pattern <= 1'b0;
      err_sof     <= 1'b0;
      err_cfg     <= 1'b0;
    end else begin
      data_out    <= dout_d;
      data_valid  <= dv_d;
      eof_out     <= eof_d;
      frame_ok    <= ok_d;
      err_pattern <= ep_d;
      err_sof     <= es_d;
      err_cfg     <= ec_d;
    end
  end

endmodule

// File: tb/tb_data_destuffer.sv
// Self-checking bench for data_destuffer.
// Reference marker derived from floor(k*cm/pm) arithmetic.
module tb_data_destuffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pm;
  logic [7:0] cm;
  logic       sof;
  logic       valid_in;
  logic       ds_in;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       eof_out;
  logic       frame_ok;
  logic       err_pattern;
  logic       err_sof;
  logic       err_cfg;

  int checks   = 0;
  int failures = 0;

  logic       f_ds[16];
  logic [7:0] f_dat[16];

  logic       c_dv, c_eof, c_ok, c_ep, c_es, c_ec;
  logic [7:0] c_do;

  data_destuffer #(
    .MPT_W  (8),
    .DATA_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pm          (pm),
    .cm          (cm),
    .sof         (sof),
    .valid_in    (valid_in),
    .ds_in       (ds_in),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .eof_out     (eof_out),
    .frame_ok    (frame_ok),
    .err_pattern (err_pattern),
    .err_sof     (err_sof),
    .err_cfg     (err_cfg)
  );

  always #5 clk = ~clk;

  function automatic int marker(input int p, input int c, input int k);
    return (k * c) / p - ((k - 1) * c) / p;
  endfunction

  task automatic cycle(input logic s, input logic v,
                       input logic d, input logic [7:0] dat);
    sof      = s;
    valid_in = v;
    ds_in    = d;
    data_in  = dat;
    @(posedge clk);
    #1;
    c_dv  = data_valid;
    c_do  = data_out;
    c_eof = eof_out;
    c_ok  = frame_ok;
    c_ep  = err_pattern;
    c_es  = err_sof;
    c_ec  = err_cfg;
    sof      = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic run_frame(input int p, input int c, input int maxgap,
                           input bit sv, input bit exp_es, input string nm,
                           output int dv_cnt, output int ep_cnt,
                           output bit ok_seen);
    int   n_data;
    bit   bad;
    int   m;
    logic [5:0] got;
    logic [5:0] exp;
    n_data  = 0;
    bad     = 0;
    dv_cnt  = 0;
    ep_cnt  = 0;
    ok_seen = 0;
    pm = 8'(p);
    cm = 8'(c);
    cycle(1'b1, sv, 1'b1, 8'h55);
    got = {c_dv, c_eof, c_ok, c_ep, c_es, c_ec};
    exp = {4'b0000, exp_es, 1'b0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s_sof flags got=%b want=%b", nm, got, exp);
    end
    for (int k = 1; k <= p; k++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int j = 0; j < g; j++) begin
        cycle(1'b0, 1'b0, 1'($urandom), 8'($urandom));
        checks++;
        if ({c_dv, c_eof, c_ep} !== 3'b000) begin
          failures++;
          $display("FAIL %s_gap slot=%0d got=%b want=000",
                   nm, k, {c_dv, c_eof, c_ep});
        end
      end
      m = marker(p, c, k);
      if (int'(f_ds[k-1]) != m) bad = 1;
      n_data += int'(f_ds[k-1]);
      cycle(1'b0, 1'b1, f_ds[k-1], f_dat[k-1]);
      exp = {f_ds[k-1], (k == p),
             (k == p) && !bad && (n_data == c),
             (int'(f_ds[k-1]) != m), 2'b00};
      got = {c_dv, c_eof, c_ok, c_ep, c_es, c_ec};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s_slot%0d flags got=%b want=%b", nm, k, got, exp);
      end
      if (f_ds[k-1]) begin
        checks++;
        if (c_do !== f_dat[k-1]) begin
          failures++;
          $display("FAIL %s_slot%0d data got=%h want=%h",
                   nm, k, c_do, f_dat[k-1]);
        end
      end
      if (c_dv === 1'b1) dv_cnt++;
      if (c_ep === 1'b1) ep_cnt++;
      if (c_ok === 1'b1) ok_seen = 1;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    pm       = '0;
    cm       = '0;
    sof      = 1'b0;
    valid_in = 1'b0;
    ds_in    = 1'b0;
    data_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({data_out, data_valid, eof_out, frame_ok,
         err_pattern, err_sof, err_cfg} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {data_out, data_valid, eof_out, frame_ok,
                err_pattern, err_sof, err_cfg});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 1'b1, 8'hEE);
    checks++;
    if ({c_dv, c_eof, c_ep} !== 3'b000) begin
      failures++;
      $display("FAIL idle_ignore got=%b want=000", {c_dv, c_eof, c_ep});
    end
  endtask

  task automatic test_basic();
    int dvn, epn;
    bit ok;
    f_ds[0] = 0; f_ds[1] = 1; f_ds[2] = 0; f_ds[3] = 1;
    for (int i = 0; i < 4; i++) f_dat[i] = 8'hA0 + 8'(i);
    run_frame(4, 2, 0, 1'b0, 1'b0, "basic", dvn, epn, ok);
    checks++;
    if (dvn != 2 || epn != 0 || !ok) begin
      failures++;
      $display("FAIL basic_summary dv=%0d ep=%0d ok=%0d want 2 0 1",
               dvn, epn, ok);
    end
  endtask

  task automatic test_gaps();
    int dvn, epn;
    bit ok;
    f_ds[0] = 0; f_ds[1] = 1; f_ds[2] = 0; f_ds[3] = 1; f_ds[4] = 1;
    for (int i = 0; i < 5; i++) f_dat[i] = 8'(i);
    run_frame(5, 3, 3, 1'b0, 1'b0, "gaps", dvn, epn, ok);
    checks++;
    if (dvn != 3 || epn != 0 || !ok) begin
      failures++;
      $display("FAIL gaps_summary dv=%0d ep=%0d ok=%0d want 3 0 1",
               dvn, epn, ok);
    end
    f_ds[0] = 1; f_ds[1] = 1; f_ds[2] = 0; f_ds[3] = 1; f_ds[4] = 0;
    run_frame(5, 3, 2, 1'b0, 1'b0, "badpat", dvn, epn, ok);
    checks++;
    if (dvn != 3 || epn != 2 || ok) begin
      failures++;
      $display("FAIL badpat_summary dv=%0d ep=%0d ok=%0d want 3 2 0",
               dvn, epn, ok);
    end
  endtask

  task automatic test_extremes();
    int dvn, epn;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      f_ds[i]  = 1;
      f_dat[i] = 8'hC0 + 8'(i);
    end
    run_frame(3, 3, 0, 1'b0, 1'b0, "full", dvn, epn, ok);
    checks++;
    if (dvn != 3 || !ok) begin
      failures++;
      $display("FAIL full_summary dv=%0d ok=%0d want 3 1", dvn, ok);
    end
    for (int i = 0; i < 3; i++) f_ds[i] = 0;
    run_frame(3, 0, 0, 1'b0, 1'b0, "empty", dvn, epn, ok);
    checks++;
    if (dvn != 0 || !ok) begin
      failures++;
      $display("FAIL empty_summary dv=%0d ok=%0d want 0 1", dvn, ok);
    end
  endtask

  task automatic test_sof_priority();
    int dvn, epn;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      f_ds[i]  = 1;
      f_dat[i] = 8'h10 + 8'(i);
    end
    run_frame(4, 4, 0, 1'b1, 1'b0, "sofvalid", dvn, epn, ok);
    checks++;
    if (dvn != 4 || !ok) begin
      failures++;
      $display("FAIL sofvalid_summary dv=%0d ok=%0d want 4 1", dvn, ok);
    end
  endtask

  task automatic test_abort_cfg();
    int dvn, epn;
    bit ok;
    pm = 8'd6;
    cm = 8'd2;
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 1'b1, 1'(marker(6, 2, k)), 8'h30 + 8'(k));
    end
    checks++;
    if (c_dv !== 1'b1 || c_do !== 8'h33) begin
      failures++;
      $display("FAIL abort_slot3 dv=%b data=%h want 1 33", c_dv, c_do);
    end
    f_ds[0] = 0; f_ds[1] = 0; f_ds[2] = 1;
    for (int i = 0; i < 3; i++) f_dat[i] = 8'h40 + 8'(i);
    run_frame(3, 1, 1, 1'b1, 1'b1, "restart", dvn, epn, ok);
    checks++;
    if (dvn != 1 || epn != 0 || !ok) begin
      failures++;
      $display("FAIL restart_summary dv=%0d ep=%0d ok=%0d want 1 0 1",
               dvn, epn, ok);
    end
    pm = 8'd0;
    cm = 8'd0;
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({c_ec, c_es, c_dv} !== 3'b100) begin
      failures++;
      $display("FAIL cfg_pm0 got=%b want=100", {c_ec, c_es, c_dv});
    end
    cycle(1'b0, 1'b1, 1'b1, 8'hAA);
    checks++;
    if ({c_dv, c_eof, c_ep} !== 3'b000) begin
      failures++;
      $display("FAIL cfg_pm0_idle got=%b want=000", {c_dv, c_eof, c_ep});
    end
    pm = 8'd4;
    cm = 8'd7;
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({c_ec, c_es, c_dv} !== 3'b100) begin
      failures++;
      $display("FAIL cfg_cm_gt got=%b want=100", {c_ec, c_es, c_dv});
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, 1'b1, 8'hBB);
      checks++;
      if ({c_dv, c_eof, c_ep} !== 3'b000) begin
        failures++;
        $display("FAIL cfg_cm_gt_idle got=%b want=000", {c_dv, c_eof, c_ep});
      end
    end
  endtask

  task automatic test_reset_midframe();
    int dvn, epn;
    bit ok;
    pm = 8'd4;
    cm = 8'd4;
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, 8'h21);
    cycle(1'b0, 1'b1, 1'b1, 8'h22);
    checks++;
    if (c_dv !== 1'b1 || c_do !== 8'h22) begin
      failures++;
      $display("FAIL rstmid_pre dv=%b data=%h want 1 22", c_dv, c_do);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_out, data_valid, eof_out, frame_ok,
         err_pattern, err_sof, err_cfg} !== 14'd0) begin
      failures++;
      $display("FAIL rstmid_async got=%h want=0",
               {data_out, data_valid, eof_out, frame_ok,
                err_pattern, err_sof, err_cfg});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b1, 8'h60 + 8'(k));
      checks++;
      if ({c_dv, c_eof, c_ep} !== 3'b000) begin
        failures++;
        $display("FAIL rstmid_ignore got=%b want=000", {c_dv, c_eof, c_ep});
      end
    end
    for (int i = 0; i < 4; i++) begin
      f_ds[i]  = 1;
      f_dat[i] = 8'h70 + 8'(i);
    end
    run_frame(4, 4, 0, 1'b0, 1'b0, "rstmid_new", dvn, epn, ok);
    checks++;
    if (dvn != 4 || !ok) begin
      failures++;
      $display("FAIL rstmid_new_summary dv=%0d ok=%0d want 4 1", dvn, ok);
    end
  endtask

  task automatic test_random();
    int dvn, epn, tot_dv, tot_ep, n_ok;
    bit ok;
    tot_dv = 0;
    tot_ep = 0;
    n_ok   = 0;
    for (int f = 0; f < 40; f++) begin
      int p, c;
      p = int'($urandom_range(1, 16));
      c = int'($urandom_range(0, p));
      for (int k = 1; k <= p; k++) begin
        f_ds[k-1]  = 1'(marker(p, c, k)) ^ ($urandom_range(0, 7) == 0);
        f_dat[k-1] = 8'($urandom);
      end
      run_frame(p, c, 2, 1'($urandom), 1'b0, "rand", dvn, epn, ok);
      tot_dv += dvn;
      tot_ep += epn;
      if (ok) n_ok++;
    end
    $display("random frames: words=%0d pattern_errs=%0d good=%0d",
             tot_dv, tot_ep, n_ok);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_extremes();
    test_sof_priority();
    test_abort_cfg();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
